// File: rtl/stream_demux_if.sv
// Bus bundle for stream_demux: one select-tagged input stream and N one-hot output channels.
// The slave modport is the demux side; the master modport is the producer/consumer side.
interface stream_demux_if #(
  parameter int N = 3,
  parameter int W = 8
);
  localparam int SELW = $clog2(N);

  logic            in_valid;
  logic            in_ready;
  logic [SELW-1:0] in_sel;
  logic [W-1:0]    in_data;
  logic [N-1:0]    out_valid;
  logic [N-1:0]    out_ready;
  logic [W-1:0]    out_data;
  logic            sel_err;

  modport slave (
    input  in_valid, in_sel, in_data, out_ready,
    output in_ready, out_valid, out_data, sel_err
  );

  modport master (
    output in_valid, in_sel, in_data, out_ready,
    input  in_ready, out_valid, out_data, sel_err
  );
endinterface

// File: rtl/stream_demux.sv
// Registered 1:N stream demultiplexer with a single-entry output register.
// Optional delivered-beat counter (beat_cnt) is built when STREAM_DEMUX_CNT_EN is defined.
module stream_demux #(
  parameter int N = 3,
  parameter int W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  stream_demux_if.slave bus
`ifdef STREAM_DEMUX_CNT_EN
  ,
  output logic [15:0]   beat_cnt
`endif
);
  localparam int SELW = $clog2(N);
  localparam logic [SELW:0]   N_LIM  = (SELW+1)'(N);
  localparam logic [N-1:0]    ONE_HOT = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic {EMPTY, FULL} state_t;

  state_t          state_p1;
  logic [SELW-1:0] tgt_p1;
  logic [W-1:0]    data_p1;
  logic            sel_err_p1;

  logic in_xfer;
  logic sel_ok;
  logic drain;

  // Drain only looks at the ready of the channel currently holding the beat.
  assign drain   = (state_p1 == FULL) && bus.out_ready[tgt_p1];
  assign sel_ok  = ({1'b0, bus.in_sel} < N_LIM);
  assign in_xfer = bus.in_valid && bus.in_ready;

  assign bus.in_ready  = (state_p1 == EMPTY) || bus.out_ready[tgt_p1];
  assign bus.out_valid = (state_p1 == FULL) ? (ONE_HOT << tgt_p1) : '0;
  assign bus.out_data  = data_p1;
  assign bus.sel_err   = sel_err_p1;

  // Stage p1: output register; a bad select is swallowed as if no input came.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p1   <= EMPTY;
      tgt_p1     <= '0;
      data_p1    <= '0;
      sel_err_p1 <= 1'b0;
    end else begin
      sel_err_p1 <= in_xfer && !sel_ok;
      if (in_xfer && sel_ok) begin
        state_p1 <= FULL;
        tgt_p1   <= bus.in_sel;
        data_p1  <= bus.in_data;
      end else if (drain) begin
        state_p1 <= EMPTY;
      end
    end
  end

`ifdef STREAM_DEMUX_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
    end else if (drain) begin
      beat_cnt <= beat_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_stream_demux.sv
// Directed self-checking bench for stream_demux (N=3, W=8); the beat counter
// section runs only when STREAM_DEMUX_CNT_EN is defined.
module tb_stream_demux;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  stream_demux_if #(.N(3), .W(8)) bus ();
`ifdef STREAM_DEMUX_CNT_EN
  logic [15:0] beat_cnt;
`endif

  stream_demux #(.N(3), .W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave)
`ifdef STREAM_DEMUX_CNT_EN
    ,
    .beat_cnt (beat_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] sel, input logic [7:0] d);
    bus.in_valid = v;
    bus.in_sel   = sel;
    bus.in_data  = d;
  endtask

  always @(negedge clk) begin
    check_val("onehot0", 32'($onehot0(bus.out_valid)), 32'd1);
  end

  logic [1:0] seq_sel [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
  logic [2:0] seq_exp [4] = '{3'b001, 3'b010, 3'b100, 3'b001};

  initial begin
    drive(1'b0, 2'd0, 8'h00);
    bus.out_ready = 3'b000;
    repeat (3) step();
    check_val("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check_val("rst_out_data",  32'(bus.out_data),  32'h0);
    check_val("rst_sel_err",   32'(bus.sel_err),   32'h0);
    check_val("rst_in_ready",  32'(bus.in_ready),  32'h1);
    rst_n = 1'b1;
    step();

    // Reset while FULL on channel 2 clears outputs asynchronously.
    drive(1'b1, 2'd2, 8'h3C);
    step();
    drive(1'b0, 2'd0, 8'h00);
    check_val("t1_full_valid", 32'(bus.out_valid), 32'h4);
    check_val("t1_full_data",  32'(bus.out_data),  32'h3C);
    #1 rst_n = 1'b0;
    #1;
    check_val("t1_async_valid", 32'(bus.out_valid), 32'h0);
    check_val("t1_async_data",  32'(bus.out_data),  32'h0);
    step();
    rst_n = 1'b1;
    step();

    // Single beat.
    bus.out_ready = 3'b111;
    drive(1'b1, 2'd1, 8'hA5);
    check_val("t2_in_ready", 32'(bus.in_ready), 32'h1);
    step();
    drive(1'b0, 2'd0, 8'h00);
    check_val("t2_valid", 32'(bus.out_valid), 32'h2);
    check_val("t2_data",  32'(bus.out_data),  32'hA5);
    step();
    check_val("t2_empty", 32'(bus.out_valid), 32'h0);

    // Streaming at one beat per clock.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, seq_sel[i], 8'(i + 1));
      check_val("t3_in_ready", 32'(bus.in_ready), 32'h1);
      step();
      check_val("t3_valid", 32'(bus.out_valid), 32'(seq_exp[i]));
      check_val("t3_data",  32'(bus.out_data),  32'(i + 1));
    end
    drive(1'b0, 2'd0, 8'h00);
    step();
    check_val("t3_empty", 32'(bus.out_valid), 32'h0);

    // Backpressure on channel 0; other readies must be ignored.
    bus.out_ready = 3'b110;
    drive(1'b1, 2'd0, 8'h11);
    step();
    drive(1'b1, 2'd2, 8'h22);
    check_val("t4_in_ready_lo", 32'(bus.in_ready), 32'h0);
    for (int i = 0; i < 2; i++) begin
      step();
      check_val("t4_hold_valid", 32'(bus.out_valid), 32'h1);
      check_val("t4_hold_data",  32'(bus.out_data),  32'h11);
      check_val("t4_hold_ready", 32'(bus.in_ready),  32'h0);
    end
    bus.out_ready = 3'b111;
    #1;
    check_val("t4_in_ready_hi", 32'(bus.in_ready), 32'h1);
    step();
    drive(1'b0, 2'd0, 8'h00);
    check_val("t4_next_valid", 32'(bus.out_valid), 32'h4);
    check_val("t4_next_data",  32'(bus.out_data),  32'h22);
    step();
    check_val("t4_empty", 32'(bus.out_valid), 32'h0);

    // Bad select from EMPTY.
    drive(1'b1, 2'd3, 8'hFF);
    check_val("t5_in_ready", 32'(bus.in_ready), 32'h1);
    step();
    drive(1'b0, 2'd0, 8'h00);
    check_val("t5_sel_err", 32'(bus.sel_err),   32'h1);
    check_val("t5_valid",   32'(bus.out_valid), 32'h0);
    step();
    check_val("t5_sel_err_end", 32'(bus.sel_err),   32'h0);
    check_val("t5_valid_end",   32'(bus.out_valid), 32'h0);

    // Bad select while FULL and draining: drain rule applies, no load.
    bus.out_ready = 3'b000;
    drive(1'b1, 2'd1, 8'h44);
    step();
    drive(1'b1, 2'd3, 8'hEE);
    check_val("t5b_in_ready_lo", 32'(bus.in_ready), 32'h0);
    bus.out_ready = 3'b010;
    #1;
    check_val("t5b_in_ready_hi", 32'(bus.in_ready), 32'h1);
    step();
    drive(1'b0, 2'd0, 8'h00);
    check_val("t5b_sel_err", 32'(bus.sel_err),   32'h1);
    check_val("t5b_valid",   32'(bus.out_valid), 32'h0);
    step();

`ifdef STREAM_DEMUX_CNT_EN
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_val("t6_cnt_rst", 32'(beat_cnt), 32'h0);
    bus.out_ready = 3'b111;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'(i % 3), 8'(i));
      step();
    end
    drive(1'b1, 2'd3, 8'hFF);
    step();
    drive(1'b0, 2'd0, 8'h00);
    step();
    check_val("t6_cnt5", 32'(beat_cnt), 32'd5);
    for (int i = 0; i < 65530; i++) begin
      drive(1'b1, 2'(i % 3), 8'(i));
      step();
    end
    drive(1'b0, 2'd0, 8'h00);
    step();
    check_val("t6_cnt_max", 32'(beat_cnt), 32'hFFFF);
    drive(1'b1, 2'd1, 8'h5A);
    step();
    drive(1'b0, 2'd0, 8'h00);
    step();
    check_val("t6_cnt_wrap", 32'(beat_cnt), 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
